// File: rtl/scan_chain_ctrl_if.sv
// ---------------------------------------------------------------------------
// scan_chain_ctrl_if
// Host-side handshake bundle for the scan-chain controller.
//   start   : transaction request (host -> controller)
//   mode    : 0 = write (shift then LOAD), 1 = readback (shift only)
//   wr_data : word shifted into the chain, captured with start
//   busy    : transaction in progress (controller -> host)
//   done    : one-cycle completion pulse
//   rd_data : word captured from SCAN_OUT during the last transaction
// ---------------------------------------------------------------------------
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 64
);
  logic                 start;
  logic                 mode;
  logic [CHAIN_LEN-1:0] wr_data;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] rd_data;

  modport master (
    output start, mode, wr_data,
    input  busy, done, rd_data
  );

  modport slave (
    input  start, mode, wr_data,
    output busy, done, rd_data
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// scan_chain_ctrl
// Serialises a CHAIN_LEN-bit word into a scan chain using non-overlapping
// two-phase scan clocks, captures the chain's serial output back into
// rd_data, and (for writes) strobes LOAD to transfer the chain to its shadow
// latches. Each scan phase lasts DIV system-clock cycles.
//
// Ports:
//   clock    : system clock (single domain)
//   reset    : asynchronous active-high reset
//   bus      : host handshake (start/mode/wr_data in, busy/done/rd_data out)
//   PHI/PHIB : two-phase scan clocks, registered, never high together
//   SCAN_IN  : serial data to the chain, MSB first
//   LOAD     : chain-to-shadow strobe, write transactions only
//   i0o1     : chain direction, captured mode while busy, else 0
//   SCAN_OUT : serial data from the chain
// ---------------------------------------------------------------------------
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 64,
  parameter int DIV       = 2
) (
  input  logic             clock,
  input  logic             reset,
  scan_chain_ctrl_if.slave bus,
  output logic             PHI,
  output logic             PHIB,
  output logic             SCAN_IN,
  output logic             LOAD,
  output logic             i0o1,
  input  logic             SCAN_OUT
);

  localparam int               BIT_W      = $clog2(CHAIN_LEN + 1);
  localparam logic [7:0]       PHASE_LAST = 8'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, PH1, GAP, PH2, LOADP, FIN
  } state_t;

  state_t               state, state_n;
  logic [7:0]           phase_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CHAIN_LEN-1:0] shift_q;
  logic [CHAIN_LEN-1:0] rd_q;
  logic                 mode_q;
  logic                 phi_q, phib_q, load_q, busy_q, done_q;

  logic accept;
  logic phase_end;
  logic bit_end;
  logic shifting;
  logic timed;

  assign accept    = (state == IDLE) && bus.start;
  assign phase_end = (phase_cnt == PHASE_LAST);
  assign bit_end   = (state == PH2) && phase_end;
  assign shifting  = state inside {SETUP, PH1, GAP, PH2};
  assign timed     = shifting || (state == LOADP);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update from pre-edge values and simulation order cannot change results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // -------------------------------------------------------------------------
  // Next-state logic. start is only looked at in IDLE, so requests while
  // busy or during FIN are dropped rather than queued.
  // -------------------------------------------------------------------------
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = SETUP;
      SETUP:   if (phase_end) state_n = PH1;
      PH1:     if (phase_end) state_n = GAP;
      GAP:     if (phase_end) state_n = PH2;
      PH2: begin
        if (phase_end) begin
          if (bit_cnt != BIT_LAST) state_n = SETUP;
          else if (mode_q)         state_n = FIN;
          else                     state_n = LOADP;
        end
      end
      LOADP:   if (phase_end) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Phase and bit counters. The phase counter restarts on every state change
  // so each timed state lasts exactly DIV cycles; it tops out at DIV-1.
  // The bit counter ends at CHAIN_LEN, which its width still holds.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
      bit_cnt   <= '0;
    end else begin
      if (state_n != state) phase_cnt <= '0;
      else if (timed)       phase_cnt <= phase_cnt + 8'd1;

      if (accept)       bit_cnt <= '0;
      else if (bit_end) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: outgoing word shifts left so its MSB is always the bit on
  // SCAN_IN; incoming samples enter at the LSB on the last PH2 cycle.
  // -------------------------------------------------------------------------
  // NOTE: the data registers are reset as well, because rd_data must read
  // zero after reset and must not expose a previous transaction's word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      rd_q    <= '0;
      mode_q  <= 1'b0;
    end else begin
      if (accept) begin
        shift_q <= bus.wr_data;
        mode_q  <= bus.mode;
      end else if (bit_end) begin
        shift_q <= {shift_q[CHAIN_LEN-2:0], 1'b0};
      end

      if (bit_end) rd_q <= {rd_q[CHAIN_LEN-2:0], SCAN_OUT};
    end
  end

  // -------------------------------------------------------------------------
  // Registered outputs decoded from the next state, so they line up with the
  // state they belong to and come straight off flops (glitch-free clocks).
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phi_q  <= 1'b0;
      phib_q <= 1'b0;
      load_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      phi_q  <= (state_n == PH1);
      phib_q <= (state_n == PH2);
      load_q <= (state_n == LOADP);
      busy_q <= !(state_n inside {IDLE, FIN});
      done_q <= (state_n == FIN);
    end
  end

  assign PHI         = phi_q;
  assign PHIB        = phib_q;
  assign LOAD        = load_q;
  assign SCAN_IN     = shifting && shift_q[CHAIN_LEN-1];
  assign i0o1        = busy_q && mode_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_chain_ctrl
// Three controllers (DIV = 1, 2, 3; CHAIN_LEN = 8) share host stimulus; one
// is selected at a time and its outputs are observed through a mux. Expected
// results are pushed to a scoreboard when a transaction is launched and
// popped when the selected controller pulses done. A small two-phase chain
// model provides SCAN_OUT for the loopback case.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_chain_ctrl;

  localparam int CL = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Host stimulus
  logic          start_drv;
  logic          mode_drv;
  logic [CL-1:0] wr_drv;
  logic [1:0]    sel;
  logic          so_const;
  logic          use_chain;
  logic          scan_out_drv;

  scan_chain_ctrl_if #(.CHAIN_LEN(CL)) bus1 ();
  scan_chain_ctrl_if #(.CHAIN_LEN(CL)) bus2 ();
  scan_chain_ctrl_if #(.CHAIN_LEN(CL)) bus3 ();

  assign bus1.start   = start_drv && (sel == 2'd1);
  assign bus2.start   = start_drv && (sel == 2'd2);
  assign bus3.start   = start_drv && (sel == 2'd3);
  assign bus1.mode    = mode_drv;
  assign bus2.mode    = mode_drv;
  assign bus3.mode    = mode_drv;
  assign bus1.wr_data = wr_drv;
  assign bus2.wr_data = wr_drv;
  assign bus3.wr_data = wr_drv;

  logic [3:1] phi_a, phib_a, si_a, load_a, io_a;

  scan_chain_ctrl #(.CHAIN_LEN(CL), .DIV(1)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1),
    .PHI(phi_a[1]), .PHIB(phib_a[1]), .SCAN_IN(si_a[1]), .LOAD(load_a[1]),
    .i0o1(io_a[1]), .SCAN_OUT(scan_out_drv)
  );
  scan_chain_ctrl #(.CHAIN_LEN(CL), .DIV(2)) u_dut2 (
    .clock(clock), .reset(reset), .bus(bus2),
    .PHI(phi_a[2]), .PHIB(phib_a[2]), .SCAN_IN(si_a[2]), .LOAD(load_a[2]),
    .i0o1(io_a[2]), .SCAN_OUT(scan_out_drv)
  );
  scan_chain_ctrl #(.CHAIN_LEN(CL), .DIV(3)) u_dut3 (
    .clock(clock), .reset(reset), .bus(bus3),
    .PHI(phi_a[3]), .PHIB(phib_a[3]), .SCAN_IN(si_a[3]), .LOAD(load_a[3]),
    .i0o1(io_a[3]), .SCAN_OUT(scan_out_drv)
  );

  // Observed view of the selected controller
  logic          o_busy, o_done, o_phi, o_phib, o_si, o_load, o_io;
  logic [CL-1:0] o_rd;

  always_comb begin
    case (sel)
      2'd2: begin
        o_busy = bus2.busy; o_done = bus2.done; o_rd = bus2.rd_data;
        o_phi = phi_a[2]; o_phib = phib_a[2]; o_si = si_a[2];
        o_load = load_a[2]; o_io = io_a[2];
      end
      2'd3: begin
        o_busy = bus3.busy; o_done = bus3.done; o_rd = bus3.rd_data;
        o_phi = phi_a[3]; o_phib = phib_a[3]; o_si = si_a[3];
        o_load = load_a[3]; o_io = io_a[3];
      end
      default: begin
        o_busy = bus1.busy; o_done = bus1.done; o_rd = bus1.rd_data;
        o_phi = phi_a[1]; o_phib = phib_a[1]; o_si = si_a[1];
        o_load = load_a[1]; o_io = io_a[1];
      end
    endcase
  end

  // Two-phase chain model: master follows SCAN_IN while PHI is high, the
  // chain advances when PHIB falls. Updates happen on the falling system
  // clock edge, away from the controller's sampling edge.
  logic [CL-1:0] chain;
  logic [CL-1:0] chain_init_v;
  logic          chain_load;
  logic          master;
  logic          phib_d;

  always @(negedge clock) begin
    if (chain_load) begin
      chain <= chain_init_v;
    end else begin
      if (o_phi) master <= o_si;
      if (phib_d && !o_phib) chain <= {chain[CL-2:0], master};
    end
    phib_d <= o_phib;
  end

  assign scan_out_drv = use_chain ? chain[CL-1] : so_const;

  // Checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    int            lat;
    int            load_first;
    int            load_len;
    logic [CL-1:0] sent;
    logic [CL-1:0] rd;
  } exp_t;

  exp_t sb[$];

  task automatic run_txn(input string tag, input logic [1:0] s, input int div,
                         input logic md, input logic [CL-1:0] wd, input logic so,
                         input logic use_ch, input logic [CL-1:0] ch_init,
                         input logic poke);
    exp_t e, g;
    int c, done_cyc, busy_n, io_n, io_bad, phi_n, phib_n, load_n, load_first;
    int ovl, bad_run, run_phi, run_phib, unstable;
    logic [CL-1:0] cap;
    logic phi_p, phib_p, bit_v, seen, post_busy;

    if (use_ch) begin
      chain_init_v = ch_init;
      @(posedge clock); chain_load = 1'b1;
      @(posedge clock); chain_load = 1'b0;
    end

    @(negedge clock);
    sel = s; mode_drv = md; wr_drv = wd; so_const = so; use_chain = use_ch;

    e.lat        = CL * 4 * div + (md ? 0 : div) + 1;
    e.load_first = CL * 4 * div + 1;
    e.load_len   = md ? 0 : div;
    e.sent       = wd;
    e.rd         = use_ch ? ch_init : {CL{so}};
    sb.push_back(e);

    start_drv = 1'b1;
    c = 0; done_cyc = 0; busy_n = 0; io_n = 0; io_bad = 0; phi_n = 0; phib_n = 0;
    load_n = 0; load_first = 0; ovl = 0; bad_run = 0; run_phi = 0; run_phib = 0;
    unstable = 0; cap = '0; phi_p = 0; phib_p = 0; bit_v = 0; seen = 0;

    while (!seen && c < e.lat + 40) begin
      @(negedge clock);
      c++;
      start_drv = poke && (c == 5);
      if (o_phi && o_phib) ovl++;
      if (o_busy) busy_n++;
      if (o_io) io_n++;
      if (o_io !== (o_busy & md)) io_bad++;
      if (o_phi && !phi_p) begin
        phi_n++;
        cap   = {cap[CL-2:0], o_si};
        bit_v = o_si;
      end
      if (o_phib && !phib_p) begin
        phib_n++;
        if (o_si !== bit_v) unstable++;
      end
      if (o_phi) run_phi++;
      else begin
        if (phi_p && run_phi != div) bad_run++;
        run_phi = 0;
      end
      if (o_phib) run_phib++;
      else begin
        if (phib_p && run_phib != div) bad_run++;
        run_phib = 0;
      end
      if (o_load) begin
        load_n++;
        if (load_first == 0) load_first = c;
      end
      if (o_done) begin
        seen     = 1'b1;
        done_cyc = c;
        if (o_busy) busy_n--;  // busy must be low in FIN; counted below
        check({tag, "_busy_in_fin"}, 32'(o_busy), 32'd0);
      end
      phi_p  = o_phi;
      phib_p = o_phib;
    end

    // A start during FIN must be dropped.
    if (poke) start_drv = 1'b1;
    @(negedge clock);
    start_drv = 1'b0;
    check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
    post_busy = o_busy;
    repeat (6) begin
      @(negedge clock);
      post_busy = post_busy | o_busy | o_done;
    end
    check({tag, "_idle_after"}, 32'(post_busy), 32'd0);

    g = sb.pop_front();
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"},   32'(done_cyc), 32'(g.lat));
    check({tag, "_busy_cyc"},  32'(busy_n), 32'(g.lat - 1));
    check({tag, "_i0o1_cyc"},  32'(io_n), 32'(md ? g.lat - 1 : 0));
    check({tag, "_i0o1_bad"},  32'(io_bad), 32'd0);
    check({tag, "_phi_n"},     32'(phi_n), 32'(CL));
    check({tag, "_phib_n"},    32'(phib_n), 32'(CL));
    check({tag, "_scan_word"}, 32'(cap), 32'(g.sent));
    check({tag, "_scan_stab"}, 32'(unstable), 32'd0);
    check({tag, "_overlap"},   32'(ovl), 32'd0);
    check({tag, "_run_len"},   32'(bad_run), 32'd0);
    check({tag, "_load_len"},  32'(load_n), 32'(g.load_len));
    check({tag, "_load_at"},   32'(load_first), 32'(g.load_len != 0 ? g.load_first : 0));
    check({tag, "_rd_data"},   32'(o_rd), 32'(g.rd));
    if (use_ch) check({tag, "_chain"}, 32'(chain), 32'(wd));
  endtask

  // Start a DIV=1 write, then reset it at cycle 15.
  task automatic reset_abort();
    logic pre_busy, saw;
    @(negedge clock);
    sel = 2'd1; mode_drv = 1'b0; wr_drv = 8'hA5; use_chain = 1'b0; so_const = 1'b0;
    start_drv = 1'b1;
    @(negedge clock);
    start_drv = 1'b0;
    repeat (14) @(negedge clock);
    pre_busy = o_busy;
    check("abort_busy_before", 32'(pre_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_ctrl_outs", 32'({o_busy, o_done, o_phi, o_phib, o_load, o_si, o_io}), 32'd0);
    check("abort_rd_data", 32'(o_rd), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clock);
      saw = saw | o_done | o_load | o_busy;
    end
    check("abort_quiet", 32'(saw), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_drv = 1'b0; mode_drv = 1'b0; wr_drv = '0; sel = 2'd1;
    so_const = 1'b0; use_chain = 1'b0; chain_load = 1'b0; chain_init_v = '0;

    repeat (3) @(negedge clock);
    start_drv = 1'b1;  // must be ignored while reset is held
    for (int k = 1; k <= 3; k++) begin
      sel = 2'(k);
      #1;
      check("reset_ctrl_outs", 32'({o_busy, o_done, o_phi, o_phib, o_load, o_si, o_io}), 32'd0);
      check("reset_rd_data", 32'(o_rd), 32'd0);
    end
    start_drv = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    run_txn("wr_div1",   2'd1, 1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    run_txn("rb_div1",   2'd1, 1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    reset_abort();
    run_txn("wr_after_rst", 2'd1, 1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    run_txn("loop_div3", 2'd3, 3, 1'b0, 8'h81, 1'b0, 1'b1, 8'h3C, 1'b0);
    run_txn("ovl_div2",  2'd2, 2, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
    run_txn("rb_div2",   2'd2, 2, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
